// File: rtl/bwm_sched_pkg.sv
// Shared constants and FSM state type for the bwm_mul_sched scheduler slice.
package bwm_sched_pkg;
   localparam int unsigned OPW  = 4;
   localparam int unsigned PRW  = 8;
   localparam int unsigned CNTW = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      HOLD = 2'd2
   } state_t;
endpackage

// File: rtl/bwm4_core.sv
// Combinational 4x4 signed Baugh-Wooley multiplier producing an 8-bit product.
module bwm4_core
   import bwm_sched_pkg::*;
(
   input  logic [OPW-1:0] a,
   input  logic [OPW-1:0] b,
   output logic [PRW-1:0] p
);

   logic [PRW-1:0] acc;
   logic           pp;

   // Partial products pairing one sign bit with a magnitude bit are inverted;
   // the constant 0x90 folds in the correction ones at bits 4 and 7.
   always_comb begin
      acc = 8'h90;
      pp  = 1'b0;
      for (int unsigned i = 0; i < OPW; i++) begin
         for (int unsigned j = 0; j < OPW; j++) begin
            pp = a[i] & b[j];
            if ((i == OPW - 1) != (j == OPW - 1))
               pp = ~pp;
            acc = acc + (PRW'(pp) << (i + j));
         end
      end
   end

   assign p = acc;

endmodule

// File: rtl/bwm_mul_sched.sv
// Round-robin scheduler in front of one shared bwm4_core multiplier.
// Optional accepted-request counter enabled by defining BWM_SCHED_STATS_EN.
module bwm_mul_sched
   import bwm_sched_pkg::*;
#(
   parameter  int unsigned NREQ = 4,
   localparam int unsigned IDW  = $clog2(NREQ)
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [4*NREQ-1:0]   req_x,
   input  logic [4*NREQ-1:0]   req_y,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [7:0]          rsp_p
`ifdef BWM_SCHED_STATS_EN
   ,
   output logic [15:0]         grant_cnt,
   input  logic                stats_clr
`endif
);

   state_t         state;
   logic [IDW-1:0] last_grant;
   logic [OPW-1:0] op_x;
   logic [OPW-1:0] op_y;
   logic [IDW-1:0] op_id;
   logic [PRW-1:0] core_p;

   logic [IDW:0]   pick;
   logic [IDW-1:0] win;
   logic           grant_ok;
   logic           accept;
   logic [OPW-1:0] sel_x;
   logic [OPW-1:0] sel_y;

   // Returns {found, index}; search begins one past the last accepted requester.
   function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                            input logic [IDW-1:0]  last);
      logic [IDW:0] r;
      int unsigned  idx;
      r = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = (32'(last) + k) % NREQ;
         if (!r[IDW] && v[IDW'(idx)])
            r = {1'b1, IDW'(idx)};
      end
      return r;
   endfunction

   always_comb begin
      pick     = rr_pick(req_valid, last_grant);
      win      = pick[IDW-1:0];
      grant_ok = rst_n && ((state == IDLE) || ((state == HOLD) && rsp_ready));
      accept   = grant_ok && pick[IDW];
      req_ready = '0;
      if (accept)
         req_ready[win] = 1'b1;
      sel_x = '0;
      sel_y = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (32'(win) == i) begin
            sel_x = req_x[i*OPW +: OPW];
            sel_y = req_y[i*OPW +: OPW];
         end
      end
   end

   bwm4_core u_core (
      .a (op_x),
      .b (op_y),
      .p (core_p)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= IDW'(NREQ - 1);
         op_x       <= '0;
         op_y       <= '0;
         op_id      <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_p      <= '0;
      end else begin
         if (accept) begin
            op_x       <= sel_x;
            op_y       <= sel_y;
            op_id      <= win;
            last_grant <= win;
         end
         case (state)
            IDLE: begin
               if (accept)
                  state <= MUL;
            end
            MUL: begin
               rsp_p     <= core_p;
               rsp_id    <= op_id;
               rsp_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= accept ? MUL : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BWM_SCHED_STATS_EN
   logic [CNTW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (stats_clr)
         cnt_q <= '0;
      else if (accept && (cnt_q != '1))
         cnt_q <= cnt_q + 1'b1;
   end

   assign grant_cnt = cnt_q;
`endif

endmodule
